// File: rtl/present80_core.sv
// PRESENT-80 block cipher core, one round per clock.
// Accepts a plaintext/key pair in IDLE. It runs ROUNDS rounds with key scheduling,
// then registers the whitened ciphertext together with a one-cycle done pulse.

// 4-bit PRESENT substitution box (pure combinational).
module present80_sbox (
    input  logic [3:0] orig,
    output logic [3:0] substituted
);

    // Table lookup for the PRESENT S-box.
    always_comb begin
        case (orig)
            4'h0:    substituted = 4'hC;
            4'h1:    substituted = 4'h5;
            4'h2:    substituted = 4'h6;
            4'h3:    substituted = 4'hB;
            4'h4:    substituted = 4'h9;
            4'h5:    substituted = 4'h0;
            4'h6:    substituted = 4'hA;
            4'h7:    substituted = 4'hD;
            4'h8:    substituted = 4'h3;
            4'h9:    substituted = 4'hE;
            4'hA:    substituted = 4'hF;
            4'hB:    substituted = 4'h8;
            4'hC:    substituted = 4'h4;
            4'hD:    substituted = 4'h7;
            4'hE:    substituted = 4'h1;
            4'hF:    substituted = 4'h2;
            default: substituted = 4'h0;
        endcase
    end

endmodule

module present80_core #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] plaintext,
    input  logic [79:0] key,
    output logic        busy,
    output logic        done,
    output logic [63:0] ciphertext
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam logic [4:0] LAST_RND = 5'(ROUNDS);

    fsm_t        fsm_r;
    fsm_t        fsm_nxt_s;
    logic [63:0] state_r;
    logic [79:0] rkey_r;
    logic [4:0]  rnd_r;
    logic        busy_r;
    logic        done_r;
    logic [63:0] ciphertext_r;

    logic [63:0] addkey_s;
    logic [63:0] sbox_s;
    logic [63:0] perm_s;
    logic [79:0] rot_s;
    logic [3:0]  ksub_s;
    logic [79:0] newkey_s;
    logic        last_s;

    assign addkey_s = state_r ^ rkey_r[79:16];
    assign last_s   = (rnd_r == LAST_RND);

    // Substitution layer: one S-box per state nibble.
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_sbox
            present80_sbox u_sbox (
                .orig        (addkey_s[4*g +: 4]),
                .substituted (sbox_s[4*g +: 4])
            );
        end
        // Permutation layer: bit i moves to (16*i) mod 63, bit 63 stays in place.
        for (g = 0; g < 63; g++) begin : g_perm
            assign perm_s[(16*g) % 63] = sbox_s[g];
        end
    endgenerate
    assign perm_s[63] = sbox_s[63];

    // Key schedule: rotate left by 61, substitute the top nibble, then mix in the round counter.
    assign rot_s = {rkey_r[18:0], rkey_r[79:19]};

    present80_sbox u_ksbox (
        .orig        (rot_s[79:76]),
        .substituted (ksub_s)
    );

    assign newkey_s = {ksub_s, rot_s[75:20], rot_s[19:15] ^ rnd_r, rot_s[14:0]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_r <= IDLE;
        end else begin
            fsm_r <= fsm_nxt_s;
        end
    end

    // FSM next-state logic: accept start in IDLE, leave RUN after the final round.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            IDLE: begin
                if (start) begin
                    fsm_nxt_s = RUN;
                end else begin
                    fsm_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    fsm_nxt_s = IDLE;
                end else begin
                    fsm_nxt_s = RUN;
                end
            end
            default: fsm_nxt_s = IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= 64'h0;
            rkey_r       <= 80'h0;
            rnd_r        <= 5'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ciphertext_r <= 64'h0;
        end else begin
            busy_r <= (fsm_nxt_s == RUN);
            case (fsm_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= plaintext;
                        rkey_r  <= key;
                        rnd_r   <= 5'd1;
                    end
                end
                RUN: begin
                    state_r <= perm_s;
                    rkey_r  <= newkey_s;
                    if (last_s) begin
                        // Counter holds on the final round so it never wraps past 31.
                        ciphertext_r <= perm_s ^ newkey_s[79:16];
                        done_r       <= 1'b1;
                    end else begin
                        rnd_r  <= rnd_r + 5'd1;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign ciphertext = ciphertext_r;

endmodule

// File: tb/tb_present80_core.sv
// Self-checking bench for present80_core: known-answer vectors, random vectors
// against a behavioural PRESENT-80 model, back-to-back, noisy inputs and reset abort.
module tb_present80_core;

    localparam int ROUNDS = 31;
    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        busy;
    logic        done;
    logic [63:0] ciphertext;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] pt;
        logic [79:0] k;
        logic [63:0] ct;
    } vec_t;

    vec_t vecs [3] = '{
        '{64'h0000000000000000, 80'h00000000000000000000, 64'h5579C1387B228445},
        '{64'h0000000000000000, 80'hFFFFFFFFFFFFFFFFFFFF, 64'hE72C46C0F5945049},
        '{64'hFFFFFFFFFFFFFFFF, 80'h00000000000000000000, 64'hA112FFC72F68417B}
    };

    present80_core #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PRESENT-80 encryption.
    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k0);
        logic [63:0] st;
        logic [63:0] t;
        logic [63:0] p;
        logic [79:0] k;
        logic [4:0]  rc;
        int          d;
        st = pt;
        k  = k0;
        for (int r = 1; r <= ROUNDS; r++) begin
            st = st ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[st[4*n +: 4]];
            p = 64'h0;
            for (int i = 0; i < 64; i++) begin
                d = (i == 63) ? 63 : (16 * i) % 63;
                p[d] = t[i];
            end
            st = p;
            k = (k << 61) | (k >> 19);
            k[79:76] = SB[k[79:76]];
            rc = r[4:0];
            k[19:15] = k[19:15] ^ rc;
        end
        return st ^ k[79:16];
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_pair(output logic [63:0] pt, output logic [79:0] k);
        logic [95:0] tmp;
        tmp = {$urandom, $urandom, $urandom};
        k   = tmp[79:0];
        pt  = {$urandom, $urandom};
    endtask

    task automatic do_start(input logic [63:0] pt, input logic [79:0] k);
        @(negedge clk);
        start     = 1'b1;
        plaintext = pt;
        key       = k;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge; returns at the done-cycle negedge.
    task automatic wait_done(input string tag, input logic [63:0] exp, input bit noisy);
        int cnt = 0;
        bit busy_ok = 1'b1;
        logic [63:0] pt;
        logic [79:0] k;
        while (cnt < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (noisy) begin
                rand_pair(pt, k);
                start     = 1'b1;
                plaintext = pt;
                key       = k;
            end
            @(negedge clk);
            cnt++;
            if (done) break;
        end
        start = 1'b0;
        check({tag, " latency"}, 80'(cnt), 80'(ROUNDS));
        check({tag, " busy during run"}, 80'(busy_ok), 80'd1);
        check({tag, " done"}, 80'(done), 80'd1);
        check({tag, " busy at done"}, 80'(busy), 80'd0);
        check({tag, " ciphertext"}, 80'(ciphertext), 80'(exp));
    endtask

    task automatic after_done(input string tag, input logic [63:0] exp);
        @(negedge clk);
        check({tag, " done pulse width"}, 80'(done), 80'd0);
        check({tag, " ciphertext hold"}, 80'(ciphertext), 80'(exp));
    endtask

    initial begin
        logic [63:0] pt;
        logic [79:0] k;
        logic [63:0] exp;
        logic [63:0] pt2;
        logic [79:0] k2;
        int          extra;

        reset     = 1'b0;
        start     = 1'b1;
        plaintext = 64'hFFFFFFFFFFFFFFFF;
        key       = 80'hFFFFFFFFFFFFFFFFFFFF;

        // Reset state, with start held high (must be ignored under reset).
        repeat (3) @(negedge clk);
        check("reset busy", 80'(busy), 80'd0);
        check("reset done", 80'(done), 80'd0);
        check("reset ciphertext", 80'(ciphertext), 80'h0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post reset busy", 80'(busy), 80'd0);

        // Known-answer vectors.
        for (int v = 0; v < 3; v++) begin
            do_start(vecs[v].pt, vecs[v].k);
            wait_done($sformatf("kat%0d", v), vecs[v].ct, 1'b0);
            after_done($sformatf("kat%0d", v), vecs[v].ct);
        end

        // All ones, then a second start during the done cycle.
        do_start(64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF);
        wait_done("ones", 64'h3333DCD3213210D2, 1'b0);
        rand_pair(pt2, k2);
        start     = 1'b1;
        plaintext = pt2;
        key       = k2;
        @(negedge clk);
        start = 1'b0;
        check("b2b done pulse width", 80'(done), 80'd0);
        check("b2b busy", 80'(busy), 80'd1);
        wait_done("b2b", ref_enc(pt2, k2), 1'b0);
        after_done("b2b", ref_enc(pt2, k2));

        // Random vectors against the model.
        for (int v = 0; v < 6; v++) begin
            rand_pair(pt, k);
            do_start(pt, k);
            wait_done($sformatf("rand%0d", v), ref_enc(pt, k), 1'b0);
            after_done($sformatf("rand%0d", v), ref_enc(pt, k));
        end

        // start held high and inputs toggling during RUN.
        rand_pair(pt, k);
        exp = ref_enc(pt, k);
        @(negedge clk);
        start     = 1'b1;
        plaintext = pt;
        key       = k;
        @(negedge clk);
        wait_done("noisy", exp, 1'b1);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("noisy extra done", 80'(extra), 80'd0);
        check("noisy ciphertext hold", 80'(ciphertext), 80'(exp));

        // Reset abort at round 15.
        rand_pair(pt, k);
        do_start(pt, k);
        repeat (14) @(negedge clk);
        check("abort busy before reset", 80'(busy), 80'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort busy", 80'(busy), 80'd0);
        check("abort done", 80'(done), 80'd0);
        check("abort ciphertext", 80'(ciphertext), 80'h0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("abort no activity", 80'(extra), 80'd0);
        do_start(vecs[0].pt, vecs[0].k);
        wait_done("after abort", vecs[0].ct, 1'b0);
        after_done("after abort", vecs[0].ct);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/present80_core.md
PRESENT80_CORE -- requirements
Module: present80_core

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 31, giving the number of full rounds; legal range 1..31; reduced values are for debug only.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one encryption; sampled only in IDLE.
REQ-005 The block SHALL have port plaintext, input, 64 bits: data block; sampled only on the accepting edge.
REQ-006 The block SHALL have port key, input, 80 bits: cipher key; sampled only on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an encryption is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when ciphertext is valid.
REQ-009 The block SHALL have port ciphertext, output, 64 bits: result; holds until the next completion or reset.

Function
REQ-010 The FSM SHALL have states IDLE and RUN, and SHALL hold registers state[63:0], rkey[79:0] and rnd[4:0].
REQ-011 In IDLE with start=1, the FSM SHALL load state=plaintext, rkey=key and rnd=1, and SHALL go to RUN with busy=1 from the next cycle.
REQ-012 In IDLE with start=0, the FSM SHALL hold all registers.
REQ-013 Each RUN cycle SHALL compute state <= pLayer(sBoxLayer(state ^ rkey[79:16])).
REQ-014 The sBoxLayer SHALL use 16 instances of the existing SBox module (orig -> substituted), one per nibble; table 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-015 The pLayer SHALL move bit i to bit (16*i) mod 63 for i=0..62, and bit 63 SHALL stay at 63.
REQ-016 The key update per RUN cycle SHALL be, in order: rotate rkey left 61; pass bits [79:76] through a 17th SBox instance; XOR bits [19:15] with rnd.
REQ-017 Each RUN cycle SHALL increment rnd.
REQ-018 In the RUN cycle with rnd==ROUNDS, the block SHALL register ciphertext = newstate ^ newkey[79:16] (the final whitening key) and set done=1 for exactly one cycle.
REQ-019 In the same cycle as REQ-018, busy SHALL drop to 0 and the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be ROUNDS+1 edges: start sampled at edge E0, done and ciphertext visible after edge E(ROUNDS); for the default ROUNDS=31 this is 32 edges.
REQ-021 start asserted while in RUN SHALL be ignored, with no queueing and no effect on the running operation.
REQ-022 start asserted during the done cycle (FSM already in IDLE) SHALL be accepted, giving back-to-back throughput of one block per ROUNDS+1 cycles.
REQ-023 Changes on plaintext or key after the accepting edge SHALL NOT affect the running result.
REQ-024 The rnd register SHALL never wrap; it is reloaded to 1 on acceptance.
REQ-025 The SBox and pLayer paths SHALL be combinational, with no added pipeline stage.

Reset
REQ-026 With reset=0 at a rising edge, the block SHALL set FSM=IDLE, busy=0, done=0, ciphertext=0, state=0, rkey=0 and rnd=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation, produce no done pulse, and require a new start after reset deasserts.
REQ-028 start SHALL be ignored on any edge where reset=0.

Verification
REQ-029 Bench: plaintext=0, key=0, start pulse -> exactly 32 edges later done=1 for 1 cycle, ciphertext=5579C1387B228445.
REQ-030 Bench: plaintext=0, key=FFFFFFFFFFFFFFFFFFFF -> ciphertext=E72C46C0F5945049; plaintext=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B.
REQ-031 Bench: plaintext=all ones, key=all ones -> 3333DCD3213210D2, with a second start issued in the done cycle accepted, and its result 32 cycles later.
REQ-032 Bench: start held high throughout plus plaintext/key toggled every cycle during RUN -> result equals the values sampled at acceptance; busy stays 1 and no extra done pulses occur.
REQ-033 Bench: reset=0 asserted at round 15 -> busy=0, done=0, ciphertext=0 the next cycle; no done pulse follows; a subsequent start gives the correct ciphertext.
REQ-034 The bench SHALL follow the existing readmemh vector style (plaintext, key, expected ciphertext per line) and report vectors run and error count at the end.
